mux_scan_sampler: RTL and testbench

//  Sequencer that sits directly upstream of mux32. It drives mux32's 5-bit select through
//  0..N_INPUTS-1 and consumes mux32's 1-bit out on each step. It rebuilds the selected

---
 rtl/mux_scan_sampler.sv | 124 ++++++++++++
 tb/tb_mux_scan_sampler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sampler.sv
// Steps an external mux select through every input, samples the mux output once per
// select value, and presents the rebuilt parallel word over a valid/ready handshake.
module mux_scan_sampler #(
    parameter int N_INPUTS      = 32,
    parameter int SEL_W         = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    output logic [SEL_W-1:0]    select_o,
    input  logic                mux_out_i,
    output logic                busy_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic [N_INPUTS-1:0] word_data_o
);

    // state | meaning
    // IDLE  | waiting for start
    // SCAN  | stepping select, sampling mux_out after each settle window
    // VALID | completed word presented, waiting for word_ready
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_INPUTS - 1);

    logic [1:0]          state_q,  state_d;
    logic [SEL_W-1:0]    select_q, select_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                busy_q,   busy_d;
    logic                valid_q,  valid_d;
    logic [N_INPUTS-1:0] data_q,   data_d;
    logic [N_INPUTS-1:0] scan_q,   scan_d;

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        data_d   = data_q;
        scan_d   = scan_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SCAN;
                    select_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    scan_d   = '0;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    scan_d[select_q] = mux_out_i;
                    cnt_d            = '0;
                    if (select_q == SEL_LAST) begin
                        // Publish the whole word at once, final bit included.
                        data_d   = scan_d;
                        valid_d  = 1'b1;
                        busy_d   = 1'b0;
                        select_d = '0;
                        state_d  = VALID;
                    end else begin
                        select_d = select_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VALID: begin
                if (word_ready_i) begin
                    valid_d = 1'b0;
                    if (start_i) begin
                        state_d  = SCAN;
                        select_d = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        scan_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                select_d = '0;
                cnt_d    = '0;
                busy_d   = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            select_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            scan_q   <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            scan_q   <= scan_d;
        end
    end

    assign select_o     = select_q;
    assign busy_o       = busy_q;
    assign word_valid_o = valid_q;
    assign word_data_o  = data_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: a behavioural 32:1 mux closes the loop between
// select and mux_out; a second instance runs with a 3-cycle settle window.
module tb_mux_scan_sampler;

    logic        clk;
    logic        rst_n;
    logic        start, ready;
    logic [31:0] d;
    logic [4:0]  sel;
    logic        mux_out, busy, valid;
    logic [31:0] data;

    logic        start3, ready3;
    logic [31:0] d3;
    logic [4:0]  sel3;
    logic        mux_out3, busy3, valid3;
    logic [31:0] data3;

    int checks   = 0;
    int failures = 0;

    assign mux_out  = d[sel];
    assign mux_out3 = d3[sel3];

    mux_scan_sampler u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .select_o(sel),
        .mux_out_i(mux_out), .busy_o(busy), .word_valid_o(valid),
        .word_ready_i(ready), .word_data_o(data)
    );

    mux_scan_sampler #(.N_INPUTS(32), .SEL_W(5), .SETTLE_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start3), .select_o(sel3),
        .mux_out_i(mux_out3), .busy_o(busy3), .word_valid_o(valid3),
        .word_ready_i(ready3), .word_data_o(data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one rising edge; returns at the negedge after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; ready = 0; d = '0;
        start3 = 0; ready3 = 0; d3 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sel !== 5'd0 || busy !== 1'b0 || valid !== 1'b0 || data !== 32'd0) begin
            failures++;
            $display("FAIL reset: sel=%0d busy=%b valid=%b data=%h expected 0/0/0/0", sel, busy, valid, data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b valid=%b expected 0/0", busy, valid);
        end
    endtask

    task automatic test_basic_scan();
        d = 32'hDEADBEEF; ready = 1'b1;
        pulse_start();
        for (int n = 1; n <= 32; n++) begin
            checks++;
            if (sel !== 5'(n - 1) || busy !== 1'b1 || valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_step%0d: sel=%0d busy=%b valid=%b expected %0d/1/0", n, sel, busy, valid, n - 1);
            end
            @(negedge clk);
        end
        checks++;
        if (valid !== 1'b1 || data !== 32'hDEADBEEF || busy !== 1'b0 || sel !== 5'd0) begin
            failures++;
            $display("FAIL basic_done: valid=%b data=%h busy=%b sel=%0d expected 1/deadbeef/0/0", valid, data, busy, sel);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_1cyc: valid=%b busy=%b expected 0/0", valid, busy);
        end
    endtask

    task automatic test_settle3();
        d3 = 32'h0000_0001; ready3 = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int n = 1; n <= 96; n++) begin
            checks++;
            if (sel3 !== 5'((n - 1) / 3) || valid3 !== 1'b0 || busy3 !== 1'b1) begin
                failures++;
                $display("FAIL settle3_step%0d: sel=%0d valid=%b busy=%b expected %0d/0/1", n, sel3, valid3, busy3, (n - 1) / 3);
            end
            @(negedge clk);
        end
        checks++;
        if (valid3 !== 1'b1 || data3 !== 32'h0000_0001) begin
            failures++;
            $display("FAIL settle3_done: valid=%b data=%h expected 1/00000001", valid3, data3);
        end
        ready3 = 1'b0;
    endtask

    task automatic test_stall();
        d = 32'hA5A5_5A5A; ready = 1'b0;
        pulse_start();
        repeat (32) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== 32'hA5A5_5A5A) begin
            failures++;
            $display("FAIL stall_done: valid=%b data=%h expected 1/a5a55a5a", valid, data);
        end
        for (int n = 0; n < 10; n++) begin
            start = (n == 4);
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || data !== 32'hA5A5_5A5A || busy !== 1'b0 || sel !== 5'd0) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%b data=%h busy=%b sel=%0d expected 1/a5a55a5a/0/0", n, valid, data, busy, sel);
            end
        end
        start = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: valid=%b busy=%b expected 0/0", valid, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 32'hA5A5_5A5A) begin
            failures++;
            $display("FAIL stall_idle: valid=%b busy=%b data=%h expected 0/0/a5a55a5a", valid, busy, data);
        end
    endtask

    task automatic test_async_reset();
        d = 32'h1234_5678; ready = 1'b1;
        pulse_start();
        repeat (17) @(negedge clk);
        checks++;
        if (sel !== 5'd17) begin
            failures++;
            $display("FAIL areset_pre: sel=%0d expected 17", sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sel !== 5'd0 || busy !== 1'b0 || valid !== 1'b0 || data !== 32'd0) begin
            failures++;
            $display("FAIL areset_now: sel=%0d busy=%b valid=%b data=%h expected 0/0/0/0", sel, busy, valid, data);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (sel !== 5'd0 || busy !== 1'b0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL areset_quiet%0d: sel=%0d busy=%b valid=%b expected 0/0/0", n, sel, busy, valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        d = 32'hDEADBEEF; ready = 1'b0;
        pulse_start();
        repeat (32) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL b2b_first: valid=%b data=%h expected 1/deadbeef", valid, data);
        end
        d = 32'hFFFF_0000; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1 || sel !== 5'd0) begin
            failures++;
            $display("FAIL b2b_restart: valid=%b busy=%b sel=%0d expected 0/1/0", valid, busy, sel);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || data !== 32'hFFFF_0000) begin
            failures++;
            $display("FAIL b2b_second: valid=%b data=%h expected 1/ffff0000", valid, data);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int vcount;
        vcount = 0;
        d = 32'h0F0F_3C3C; ready = 1'b1;
        pulse_start();
        for (int n = 1; n <= 40; n++) begin
            if (n == 6) begin
                checks++;
                if (sel !== 5'd5) begin
                    failures++;
                    $display("FAIL ignore_sel5: sel=%0d expected 5", sel);
                end
            end
            start = (n == 6);
            if (n == 32) begin
                checks++;
                if (valid !== 1'b0 || sel !== 5'd31) begin
                    failures++;
                    $display("FAIL ignore_early: valid=%b sel=%0d expected 0/31", valid, sel);
                end
            end
            if (n == 33) begin
                checks++;
                if (valid !== 1'b1 || data !== 32'h0F0F_3C3C) begin
                    failures++;
                    $display("FAIL ignore_done: valid=%b data=%h expected 1/0f0f3c3c", valid, data);
                end
            end
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (vcount != 1) begin
            failures++;
            $display("FAIL ignore_count: valid cycles=%0d expected 1", vcount);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_settle3();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
